// File: rtl/adder_pkg.sv
// adder_pkg -- definitions shared by the serial subtractor files.
//   WIDTH_DEFAULT : default operand/result width in bits
//   state_t       : control FSM states (IDLE, RUN, DONE)
package adder_pkg;

  localparam int WIDTH_DEFAULT = 32'sd8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : adder_pkg

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if -- request/result bundle of the serial subtractor.
//   start, a, b                     : request (master -> slave)
//   busy, done, diff, borrow_out    : status/result (slave -> master)
//   ovf                             : signed overflow, only when
//                                     SERIAL_SUB_OVERFLOW_EN is defined
// Modports: master (requester / bench), slave (serial_subtractor).
interface serial_subtractor_if
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif

endinterface : serial_subtractor_if

// File: rtl/full_subtractor.sv
// full_subtractor -- one-bit subtractor cell computing a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial unsigned subtractor, one bit per clock,
// LSB first. A request takes WIDTH RUN cycles followed by one DONE cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_subtractor_if.slave (start/a/b in; busy/done/diff/borrow_out out)
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the signed
// overflow flag bus.ovf, updated and held together with diff.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_d;
  logic             fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state, datapath shifting and registered-output computation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The minuend register doubles as the difference register: each
        // consumed minuend bit leaves at the LSB while the new difference
        // bit enters at the MSB, so after WIDTH shifts it holds the result.
        a_d   = {fs_d, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        bin_d = fs_bout;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          done_d   = 1'b1;
          diff_d   = {fs_d, a_q[WIDTH-1:1]};
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // On the last bit a_q[0]/b_q[0] are the original operand MSBs
          // and fs_d is the result MSB.
          ovf_d    = (a_q[0] ^ b_q[0]) & (fs_d ^ a_q[0]);
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor -- self-checking bench for serial_subtractor (WIDTH=8).
// A table of vectors plus random operands drives requests; expected results
// are queued on each request and compared when done pulses. Hand-written
// sequences cover ignored starts, mid-RUN reset and reset/start priority.
// Define SERIAL_SUB_OVERFLOW_EN to also check ovf.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  vec_t sb[$];
  vec_t tbl[8];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.a      = a;
    v.b      = b;
    v.diff   = a - b;
    v.borrow = (a < b);
    v.ovf    = (a[7] != b[7]) && (v.diff[7] != a[7]);
    return v;
  endfunction

  // Advance to the next falling edge and score any done pulse.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done_pulse required=no_pulse");
      end else begin
        e = sb.pop_front();
        chk("diff", {24'd0, bus.diff}, {24'd0, e.diff});
        chk("borrow_out", {31'd0, bus.borrow_out}, {31'd0, e.borrow});
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
      end
    end
  endtask

  // Issue one request from IDLE and follow it through to the next IDLE cycle.
  task automatic run_op(input vec_t v);
    int n;
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    sb.push_back(v);
    tick();
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = 8'h5A;
    chk("busy_run", {31'd0, bus.busy}, 32'd1);
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("done_latency", n, W + 1);
    tick();
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("done_after", {31'd0, bus.done}, 32'd0);
    chk("diff_hold", {24'd0, bus.diff}, {24'd0, v.diff});
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    tbl[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0};
    tbl[3] = '{a: 8'hAA, b: 8'hAA, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
    tbl[4] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0, ovf: 1'b0};
    tbl[5] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
    tbl[6] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
    tbl[7] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1, ovf: 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_diff", {24'd0, bus.diff}, 32'd0);
    chk("rst_borrow", {31'd0, bus.borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif

    // Back-to-back table vectors: each start lands on the first IDLE edge.
    for (int i = 0; i < 8; i++) run_op(tbl[i]);
    for (int i = 0; i < 6; i++) run_op(mk(8'($urandom_range(255)), 8'($urandom_range(255))));

    // Starts during RUN are ignored; the first operation completes alone.
    d0        = done_cnt;
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    sb.push_back('{a: 8'h10, b: 8'h01, diff: 8'h0F, borrow: 1'b0, ovf: 1'b0});
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.b     = 8'h01;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 6;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ignored_start_latency", n, W + 1);
    for (int i = 0; i < 4; i++) tick();
    chk("ignored_start_single_done", done_cnt - d0, 32'd1);
    chk("ignored_start_idle", {31'd0, bus.busy}, 32'd0);

    // Reset in cycle 4 of RUN aborts with no done and clears the outputs.
    d0        = done_cnt;
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    sb.push_back(mk(8'h33, 8'h11));
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_diff", {24'd0, bus.diff}, 32'd0);
    chk("abort_borrow", {31'd0, bus.borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("abort_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    chk("abort_no_done", done_cnt - d0, 32'd0);
    run_op(mk(8'h33, 8'h11));

    // Reset wins over a simultaneous start.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h22;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_prio_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("rst_prio_idle", {31'd0, bus.busy}, 32'd0);
    d0 = done_cnt;
    for (int i = 0; i < 12; i++) tick();
    chk("rst_prio_no_done", done_cnt - d0, 32'd0);
    run_op(mk(8'h44, 8'h22));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-008 SHALL have port done  output  1  one-cycle pulse; diff and borrow_out are valid.
REQ-009 SHALL have port diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 SHALL have port borrow_out  output  1  high when a < b, unsigned.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1, latch a and b into shift registers, clear the borrow flop, clear the bit counter and enter RUN on that edge.
REQ-013 SHALL, in RUN, perform one bit per cycle, LSB first:
- d = a_i ^ b_i ^ bin
- bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
- shift d into diff_reg from the MSB side
- register bout as the next bin.
REQ-014 SHALL, after WIDTH RUN cycles (counter = WIDTH-1 processed), enter DONE.
REQ-015 SHALL update diff and borrow_out on entry to DONE, assert done for exactly that one cycle, then return to IDLE.
REQ-016 SHALL use this timing: start accepted at edge 0 -> done high in cycle WIDTH+1 -> the next start can be accepted at edge WIDTH+2.
REQ-017 SHALL hold diff and borrow_out stable from DONE until the next DONE.
REQ-018 SHALL ignore start while busy or done is high; the operation in progress is unaffected.
REQ-019 SHALL ignore changes on a and b after the accepting edge.
REQ-020 SHALL size the bit counter as $clog2(WIDTH) bits; it never wraps past WIDTH-1.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, force state to IDLE and clear busy, done, diff, borrow_out, the shift registers, the borrow flop and the counter, irrespective of the current state.
REQ-022 SHALL, on reset asserted mid-RUN, abort the operation with no done pulse; rst takes priority over start on the same edge.

Configuration
REQ-023 SHALL, with SERIAL_SUB_OVERFLOW_EN defined:
- add output port ovf (1 bit)
- ovf = signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]
- ovf updates with diff, is reset to 0 and is held like diff.
REQ-024 SHALL, with SERIAL_SUB_OVERFLOW_EN undefined, have no ovf port and no overflow logic.

Structure
REQ-025 SHALL place the state enum (IDLE/RUN/DONE) and the default WIDTH constant in shared package adder_pkg.
REQ-026 SHALL instantiate one sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), for the per-bit datapath; no other sub-modules.

Verification
REQ-027 SHALL cover: WIDTH=8, a=0x05, b=0x03, start at edge 0 -> done in cycle 9, diff=0x02, borrow_out=0.
REQ-028 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-029 SHALL cover: a=0xAA, b=0xAA -> diff=0x00, borrow_out=0; a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
REQ-030 SHALL cover: start pulsed at cycles 3 and 5 of an op with a=0x10, b=0x01, second a/b=0x00/0x01 -> single done, diff=0x0F; second request ignored.
REQ-031 SHALL cover: rst asserted in cycle 4 of RUN -> no done pulse, all outputs 0 the next cycle, a fresh start is accepted immediately after.
REQ-032 SHALL cover, with SERIAL_SUB_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x7F, b=0xFF -> diff=0x80, ovf=1; a=0x05, b=0x03 -> ovf=0.
